// File: rtl/tohost_reporter.sv
// Watches the core's tohost bus, latches the riscv-tests exit status, and
// streams every new non-zero value as lowercase hex ASCII over a byte handshake.
module tohost_reporter #(
   parameter int FIFO_DEPTH = 4,
   parameter bit CRLF_EN    = 1'b1
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic [31:0] tohost,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready,
   output logic        done,
   output logic        pass,
   output logic [30:0] fail_code,
   output logic        overflow
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_HEX  = 2'd1;
   localparam logic [1:0] ST_CR   = 2'd2;
   localparam logic [1:0] ST_LF   = 2'd3;

   logic [31:0]   tohost_q_r;
   logic [31:0]   mem_r [FIFO_DEPTH];
   logic [PW-1:0] wr_ptr_r;
   logic [PW-1:0] rd_ptr_r;
   logic [CW-1:0] count_r;
   logic [1:0]    state_r;
   logic [31:0]   shreg_r;
   logic [2:0]    nib_idx_r;
   logic          tx_valid_r;
   logic [7:0]    tx_data_r;
   logic          done_r;
   logic          pass_r;
   logic [30:0]   fail_code_r;
   logic          overflow_r;

   logic          event_s;
   logic          pop_s;
   logic          push_s;
   logic          drop_s;
   logic          exit_s;
   logic          handshake_s;
   logic [1:0]    state_nxt_s;
   logic [31:0]   shreg_nxt_s;
   logic [2:0]    nib_nxt_s;

   function automatic logic [7:0] hex_ascii(input logic [3:0] n);
      logic [7:0] c;
      if (n < 4'd10) begin
         c = 8'h30 + {4'h0, n};
      end else begin
         c = 8'h57 + {4'h0, n};
      end
      return c;
   endfunction

   function automatic logic [7:0] out_byte(input logic [1:0]  st,
                                           input logic [31:0] sh,
                                           input logic [2:0]  nib);
      logic [31:0] shifted;
      logic [7:0]  b;
      shifted = sh >> {nib, 2'b00};
      case (st)
         ST_HEX:  b = hex_ascii(shifted[3:0]);
         ST_CR:   b = 8'h0D;
         ST_LF:   b = 8'h0A;
         default: b = 8'h00;
      endcase
      return b;
   endfunction

   // Event detection and queue push/pop decisions
   always_comb begin
      event_s     = (tohost != tohost_q_r) && (tohost != 32'd0);
      pop_s       = (state_r == ST_IDLE) && (count_r != {CW{1'b0}});
      push_s      = event_s && ((count_r < CW'(FIFO_DEPTH)) || pop_s);
      drop_s      = event_s && !push_s;
      exit_s      = event_s && tohost[0] && !done_r;
      handshake_s = tx_valid_r && tx_ready;
   end

   // Serializer next-state logic; a popped value starts at the top nibble
   always_comb begin
      state_nxt_s = state_r;
      shreg_nxt_s = shreg_r;
      nib_nxt_s   = nib_idx_r;
      case (state_r)
         ST_IDLE: begin
            if (pop_s) begin
               state_nxt_s = ST_HEX;
               shreg_nxt_s = mem_r[rd_ptr_r];
               nib_nxt_s   = 3'd7;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_HEX: begin
            if (handshake_s) begin
               if (nib_idx_r == 3'd0) begin
                  state_nxt_s = CRLF_EN ? ST_CR : ST_IDLE;
               end else begin
                  nib_nxt_s = nib_idx_r - 3'd1;
               end
            end else begin
               state_nxt_s = ST_HEX;
            end
         end
         ST_CR: begin
            if (handshake_s) begin
               state_nxt_s = ST_LF;
            end else begin
               state_nxt_s = ST_CR;
            end
         end
         ST_LF: begin
            if (handshake_s) begin
               state_nxt_s = ST_IDLE;
            end else begin
               state_nxt_s = ST_LF;
            end
         end
         default: state_nxt_s = ST_IDLE;
      endcase
   end

   // Value queue storage and pointers; simultaneous push and pop keeps count
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem_r[i] <= 32'd0;
         end
         wr_ptr_r <= {PW{1'b0}};
         rd_ptr_r <= {PW{1'b0}};
         count_r  <= {CW{1'b0}};
      end else begin
         if (push_s) begin
            mem_r[wr_ptr_r] <= tohost;
            wr_ptr_r        <= wr_ptr_r + PW'(1);
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + PW'(1);
         end
         count_r <= count_r + CW'(push_s) - CW'(pop_s);
      end
   end

   // Serializer state with outputs registered from the next state
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_r    <= ST_IDLE;
         shreg_r    <= 32'd0;
         nib_idx_r  <= 3'd0;
         tx_valid_r <= 1'b0;
         tx_data_r  <= 8'h00;
      end else begin
         state_r    <= state_nxt_s;
         shreg_r    <= shreg_nxt_s;
         nib_idx_r  <= nib_nxt_s;
         tx_valid_r <= (state_nxt_s != ST_IDLE);
         tx_data_r  <= out_byte(state_nxt_s, shreg_nxt_s, nib_nxt_s);
      end
   end

   // Sampled tohost and sticky status flags; only the first exit write counts
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         tohost_q_r  <= 32'd0;
         done_r      <= 1'b0;
         pass_r      <= 1'b0;
         fail_code_r <= 31'd0;
         overflow_r  <= 1'b0;
      end else begin
         tohost_q_r <= tohost;
         if (exit_s) begin
            done_r      <= 1'b1;
            pass_r      <= (tohost[31:1] == 31'd0);
            fail_code_r <= tohost[31:1];
         end
         if (drop_s) begin
            overflow_r <= 1'b1;
         end
      end
   end

   assign tx_valid  = tx_valid_r;
   assign tx_data   = tx_data_r;
   assign done      = done_r;
   assign pass      = pass_r;
   assign fail_code = fail_code_r;
   assign overflow  = overflow_r;

endmodule

// File: tb/tb_tohost_reporter.sv
// Directed plus randomized bench for tohost_reporter; expected bytes and flags
// come from a queue-based model of the printed text and exit-code rules.
module tb_tohost_reporter;

   logic        CLK = 1'b0;
   logic        RST = 1'b0;
   logic [31:0] tohost = 32'd0;
   logic        tx_ready = 1'b0;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        done;
   logic        pass;
   logic [30:0] fail_code;
   logic        overflow;

   tohost_reporter #(.FIFO_DEPTH(4), .CRLF_EN(1'b1)) dut (
      .CLK(CLK), .RST(RST), .tohost(tohost),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
      .done(done), .pass(pass), .fail_code(fail_code), .overflow(overflow)
   );

   always #5 CLK = ~CLK;

   int          tests = 0;
   int          fails = 0;
   int          nbytes = 0;
   logic [7:0]  exp_q[$];
   logic [31:0] m_prev = 32'd0;
   bit          m_done = 1'b0;
   bit          m_pass = 1'b0;
   logic [30:0] m_code = 31'd0;
   bit          rnd_ready = 1'b0;
   bit          prev_stall = 1'b0;
   logic [7:0]  prev_data = 8'h00;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Byte monitor: every accepted byte must be the next expected one, and a stalled byte must hold
   always @(negedge CLK) begin
      if (RST === 1'b1) begin
         if (prev_stall) begin
            check("hold_valid", {63'd0, tx_valid}, 64'd1);
            check("hold_data", {56'd0, tx_data}, {56'd0, prev_data});
         end
         if (tx_valid && tx_ready) begin
            check("byte_expected", {63'd0, exp_q.size() > 0}, 64'd1);
            if (exp_q.size() > 0) begin
               check("byte", {56'd0, tx_data}, {56'd0, exp_q.pop_front()});
            end
            nbytes++;
         end
         prev_stall = tx_valid && !tx_ready;
         prev_data  = tx_data;
      end else begin
         prev_stall = 1'b0;
      end
   end

   task automatic push_text(input logic [31:0] v);
      string s;
      s = $sformatf("%08h", v);
      for (int i = 0; i < 8; i++) begin
         exp_q.push_back(s[i]);
      end
      exp_q.push_back(8'h0D);
      exp_q.push_back(8'h0A);
   endtask

   task automatic model_write(input logic [31:0] v, input bit accept);
      if (v != m_prev && v != 32'd0) begin
         if (v[0] && !m_done) begin
            m_done = 1'b1;
            m_code = v[31:1];
            m_pass = (v[31:1] == 31'd0);
         end
         if (accept) push_text(v);
      end
      m_prev = v;
   endtask

   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge CLK);
         #1;
         if (rnd_ready) tx_ready = 1'($urandom_range(0, 1));
      end
   endtask

   task automatic write(input logic [31:0] v, input bit accept);
      tohost = v;
      model_write(v, accept);
      step(1);
   endtask

   task automatic model_clear();
      exp_q.delete();
      m_done = 1'b0;
      m_pass = 1'b0;
      m_code = 31'd0;
      m_prev = 32'd0;
   endtask

   task automatic drain(input string tag);
      int k;
      k = 0;
      while ((exp_q.size() != 0 || tx_valid) && k < 5000) begin
         step(1);
         k++;
      end
      check({tag, "_drain"}, {63'd0, k < 5000}, 64'd1);
   endtask

   task automatic check_flags(input string tag);
      check({tag, "_done"}, {63'd0, done}, {63'd0, m_done});
      check({tag, "_pass"}, {63'd0, pass}, {63'd0, m_pass});
      check({tag, "_code"}, {33'd0, fail_code}, {33'd0, m_code});
   endtask

   task automatic do_reset();
      tohost = 32'd0;
      RST = 1'b0;
      step(2);
      model_clear();
      RST = 1'b1;
      step(1);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] v;
      logic [31:0] base;
      logic [31:0] r;
      int n0;
      int k;

      // Reset values
      step(3);
      check("rst_valid", {63'd0, tx_valid}, 64'd0);
      check("rst_data", {56'd0, tx_data}, 64'd0);
      check("rst_done", {63'd0, done}, 64'd0);
      check("rst_pass", {63'd0, pass}, 64'd0);
      check("rst_code", {33'd0, fail_code}, 64'd0);
      check("rst_ovf", {63'd0, overflow}, 64'd0);
      RST = 1'b1;
      tx_ready = 1'b1;
      step(1);

      // 1: tohost held 0
      for (int i = 0; i < 100; i++) begin
         step(1);
         if (i % 10 == 0) begin
            check("idle_valid", {63'd0, tx_valid}, 64'd0);
            check("idle_done", {63'd0, done}, 64'd0);
            check("idle_ovf", {63'd0, overflow}, 64'd0);
         end
      end

      // 2: passing exit
      write(32'h0000_0001, 1'b1);
      drain("t2");
      check("t2_done", {63'd0, done}, 64'd1);
      check("t2_pass", {63'd0, pass}, 64'd1);
      check("t2_code", {33'd0, fail_code}, 64'd0);

      // 3: failing exit, then a later exit write must not change flags
      do_reset();
      write(32'h0000_000B, 1'b1);
      drain("t3a");
      check("t3_done", {63'd0, done}, 64'd1);
      check("t3_pass", {63'd0, pass}, 64'd0);
      check("t3_code", {33'd0, fail_code}, 64'd5);
      write(32'h0000_0001, 1'b1);
      drain("t3b");
      check("t3b_pass", {63'd0, pass}, 64'd0);
      check("t3b_code", {33'd0, fail_code}, 64'd5);
      check_flags("t3m");

      // 4: back-pressure holds the first char
      tx_ready = 1'b0;
      write(32'hDEAD_BEEF, 1'b1);
      step(1);
      for (int i = 0; i < 5; i++) begin
         check("t4_valid", {63'd0, tx_valid}, 64'd1);
         check("t4_data", {56'd0, tx_data}, 64'h64);
         step(1);
      end
      tx_ready = 1'b1;
      drain("t4");

      // Random values with random back-pressure, never exceeding queue capacity
      rnd_ready = 1'b1;
      for (int i = 0; i < 40; i++) begin
         k = 0;
         while ((exp_q.size() + 9) / 10 >= 4 && k < 2000) begin
            step(1);
            k++;
         end
         r = $urandom_range(0, 9);
         v = $urandom;
         if (r == 0) v = 32'd0;
         else if (r == 1) v = tohost;
         else if (r == 2) v = v | 32'd1;
         else v = v & 32'hFFFF_FFFE;
         write(v, 1'b1);
         step($urandom_range(0, 3));
      end
      rnd_ready = 1'b0;
      tx_ready = 1'b1;
      drain("rnd");
      check("rnd_ovf", {63'd0, overflow}, 64'd0);
      check_flags("rnd");

      // 5: overflow with 7 back-to-back values, only v1..v5 survive
      tx_ready = 1'b0;
      base = $urandom;
      base = (base & 32'hFFFF_FF00) | 32'd2;
      for (int i = 0; i < 7; i++) begin
         write(base + 32'(i * 16), i < 5);
      end
      check("t5_ovf", {63'd0, overflow}, 64'd1);
      check("t5_valid", {63'd0, tx_valid}, 64'd1);
      check("t5_first", {56'd0, tx_data}, {56'd0, exp_q[0]});
      tx_ready = 1'b1;
      drain("t5");
      check("t5_count", {63'd0, exp_q.size() == 0}, 64'd1);

      // 6: reset during the third char; held value is re-reported once
      n0 = nbytes;
      write(32'h1234_5678, 1'b1);
      k = 0;
      while (nbytes < n0 + 2 && k < 50) begin
         step(1);
         k++;
      end
      check("t6_third", {56'd0, tx_data}, 64'h33);
      RST = 1'b0;
      #1;
      check("t6_valid", {63'd0, tx_valid}, 64'd0);
      check("t6_done", {63'd0, done}, 64'd0);
      check("t6_pass", {63'd0, pass}, 64'd0);
      check("t6_code", {33'd0, fail_code}, 64'd0);
      check("t6_ovf", {63'd0, overflow}, 64'd0);
      model_clear();
      step(2);
      RST = 1'b1;
      model_write(tohost, 1'b1);
      n0 = nbytes;
      drain("t6");
      check("t6_bytes", 64'(nbytes - n0), 64'd10);
      check_flags("t6");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
